spi_pred_tx: RTL
================

Name: spi_pred_tx

Overview:
- SPI responder transmit path: returns one branch-prediction result frame per SPI transaction on MISO.
- Operates in the opposite direction to the existing SPI receive path, which latches the instruction address and direction ground truth from the host.
- Sits between the predictor core and the uio MISO pin and shares the cs/sclk pins with the receive path.
- Host is the SPI initiator: mode 0, cs active-low, MSB first; samples MISO on sclk rising edge.

Parameters:
- FRAME_WIDTH, 18, bits per transmitted frame (prediction bit + correct-flag bit + 16-bit instruction address echo).
- CNT_WIDTH, 5, width of the bit counter; must satisfy 2^CNT_WIDTH > FRAME_WIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge; must run at least 8x sclk.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  SPI chip select, active-low, asynchronous to clk.
- sclk  input  1  SPI serial clock, asynchronous to clk.
- miso  output  1  serial data to host.
- load  input  1  single-cycle request to capture frame_in.
- frame_in  input  FRAME_WIDTH  frame from predictor core; bit FRAME_WIDTH-1 is sent first.
- ready  output  1  high when load will be accepted.
- tx_done  output  1  one-cycle pulse when a full frame has been clocked out.
- tx_abort  output  1  one-cycle pulse when cs deasserts mid-frame.
- underrun  output  1  one-cycle pulse when cs asserts with no frame buffered.

Behaviour:
- Reset values:
  - All outputs 0 except ready = 1.
  - state = IDLE; buffer, shift register, bit counter and full flag all 0.
  - Both synchronisers are loaded with idle levels: cs = 1, sclk = 0.
- Reset asserted mid-frame: aborts immediately. No tx_abort pulse; miso = 0 from the next cycle.
- Input synchronisation:
  - cs and sclk each pass through a 2-flop synchroniser plus a history flop.
  - Edge detect compares the synchronised value with its history: cs_fall, cs_rise, sclk_rise, sclk_fall.
  - Events act 3 clk cycles after the pin edge.
- Buffer:
  - Single FRAME_WIDTH register plus a full flag.
  - load while ready = 1 captures frame_in and sets full. A load while already full overwrites (newest prediction wins).
  - ready = 0 only in SHIFT. A load while ready = 0 is ignored.
- States:
  - IDLE (buffer empty, cs high):
    - miso = 0.
    - load -> ARMED.
    - cs_fall -> pulse underrun, go to DRAIN.
  - ARMED (buffer full, cs high):
    - cs_fall -> copy buffer into the shift register, clear full, miso = buffer MSB in that same cycle, bit counter = 0, go to SHIFT.
    - If load and cs_fall occur in the same cycle, the frame loaded in that cycle is the one transmitted.
  - SHIFT:
    - sclk_rise -> bit counter + 1.
    - sclk_fall -> shift left by one; miso = new MSB.
    - The sclk_rise that brings the counter to FRAME_WIDTH pulses tx_done and goes to DRAIN.
    - cs_rise before that point -> pulse tx_abort, discard the shift register, go to ARMED if full else IDLE. The buffer is not restored.
  - DRAIN (frame finished or underrun, cs still low):
    - miso = 0; sclk edges ignored; load accepted.
    - cs_rise -> ARMED if full else IDLE.
- cs_rise in the same cycle as the final counting sclk_rise: tx_done wins and tx_abort is not pulsed.
- tx_done, tx_abort and underrun are mutually exclusive and each lasts exactly one clk.
- Bit counter never wraps: it saturates at FRAME_WIDTH and is cleared on SHIFT entry.
- miso is registered; it holds its value between sclk_fall events and is 0 outside SHIFT.

Test Plan:
- Reset, then load frame_in = 18'h2A5C3, then an 18-clock mode-0 transaction:
  - host captures 18'h2A5C3 MSB first;
  - tx_done pulses once, 3 clk after the 18th sclk rise;
  - ready = 0 only during the transfer;
  - miso = 0 after cs rises.
- cs low with no load:
  - underrun pulses once;
  - host reads 18 zeros;
  - no tx_done.
- Load 18'h00001, then load 18'h3FFFF before cs falls:
  - host reads 18'h3FFFF.
- Load 18'h15555, deassert cs after 7 sclk rises:
  - tx_abort pulses once;
  - state returns to IDLE;
  - next transaction produces underrun.
- Load during SHIFT:
  - ignored, so ready = 0 at the load.
  - A load issued in DRAIN is sent in the next transaction; the host reads the DRAIN-loaded value.
- Assert rst at sclk rise 9 of a frame:
  - miso = 0 and ready = 1 the next cycle;
  - no pulses;
  - a following load/transaction behaves as after power-up reset.

Source files
------------

// File: rtl/spi_pred_tx_if.sv
// spi_pred_tx_if: SPI pins plus predictor-core handshake for the prediction transmit path.
interface spi_pred_tx_if #(
   parameter int FRAME_WIDTH = 18
);
   logic                   cs;
   logic                   sclk;
   logic                   miso;
   logic                   load;
   logic [FRAME_WIDTH-1:0] frame_in;
   logic                   ready;
   logic                   tx_done;
   logic                   tx_abort;
   logic                   underrun;
   modport master (
      output cs, sclk, load, frame_in,
      input  miso, ready, tx_done, tx_abort, underrun
   );
   modport slave (
      input  cs, sclk, load, frame_in,
      output miso, ready, tx_done, tx_abort, underrun
   );
endinterface

// File: rtl/spi_pred_tx.sv
// spi_pred_tx: SPI responder that shifts one buffered prediction frame out on MISO per cs-low transaction.
module spi_pred_tx #(
   parameter int FRAME_WIDTH = 18,
   parameter int CNT_WIDTH   = 5
) (
   input logic           clk,
   input logic           rst,
   spi_pred_tx_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DRAIN} state_t;
   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(FRAME_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] ALL_BITS = CNT_WIDTH'(FRAME_WIDTH);
   state_t                 r_state, w_state;
   logic [2:0]             r_cs_sync, r_sclk_sync;
   logic [FRAME_WIDTH-1:0] r_buf, w_buf, r_shift, w_shift;
   logic [CNT_WIDTH-1:0]   r_cnt, w_cnt;
   logic                   r_full, w_full, r_miso, w_miso;
   logic                   r_done, w_done, r_abort, w_abort, r_under, w_under;
   logic                   w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_load;
   // [0],[1] are the synchroniser stages, [2] holds the previous synchronised level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_sync   <= 3'b111;
         r_sclk_sync <= 3'b000;
      end else begin
         r_cs_sync   <= {r_cs_sync[1:0], bus.cs};
         r_sclk_sync <= {r_sclk_sync[1:0], bus.sclk};
      end
   end
   assign w_cs_fall   = r_cs_sync[2] & ~r_cs_sync[1];
   assign w_cs_rise   = ~r_cs_sync[2] & r_cs_sync[1];
   assign w_sclk_rise = ~r_sclk_sync[2] & r_sclk_sync[1];
   assign w_sclk_fall = r_sclk_sync[2] & ~r_sclk_sync[1];
   assign w_load      = bus.load & (r_state != SHIFT);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_buf   <= '0;
         r_shift <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
         r_miso  <= 1'b0;
         r_done  <= 1'b0;
         r_abort <= 1'b0;
         r_under <= 1'b0;
      end else begin
         r_state <= w_state;
         r_buf   <= w_buf;
         r_shift <= w_shift;
         r_cnt   <= w_cnt;
         r_full  <= w_full;
         r_miso  <= w_miso;
         r_done  <= w_done;
         r_abort <= w_abort;
         r_under <= w_under;
      end
   end
   always_comb begin
      w_state = r_state;
      w_buf   = w_load ? bus.frame_in : r_buf;
      w_full  = r_full | w_load;
      w_shift = r_shift;
      w_cnt   = r_cnt;
      w_miso  = r_miso;
      w_done  = 1'b0;
      w_abort = 1'b0;
      w_under = 1'b0;
      case (r_state)
         IDLE: begin
            w_miso = 1'b0;
            if (w_cs_fall) begin
               w_under = 1'b1;
               w_state = DRAIN;
            end else if (w_load) begin
               w_state = ARMED;
            end
         end
         ARMED: begin
            w_miso = 1'b0;
            // w_buf already carries a same-cycle load, so the newest frame is sent
            if (w_cs_fall) begin
               w_shift = w_buf;
               w_full  = 1'b0;
               w_miso  = w_buf[FRAME_WIDTH-1];
               w_cnt   = '0;
               w_state = SHIFT;
            end
         end
         SHIFT: begin
            if (w_sclk_rise && r_cnt == LAST_BIT) begin
               w_cnt   = ALL_BITS;
               w_done  = 1'b1;
               w_miso  = 1'b0;
               w_shift = '0;
               w_state = DRAIN;
            end else if (w_cs_rise) begin
               w_abort = 1'b1;
               w_miso  = 1'b0;
               w_shift = '0;
               w_state = r_full ? ARMED : IDLE;
            end else if (w_sclk_rise) begin
               w_cnt = (r_cnt == ALL_BITS) ? r_cnt : r_cnt + 1'b1;
            end else if (w_sclk_fall) begin
               w_shift = r_shift << 1;
               w_miso  = r_shift[FRAME_WIDTH-2];
            end
         end
         DRAIN: begin
            w_miso = 1'b0;
            if (w_cs_rise) w_state = w_full ? ARMED : IDLE;
         end
      endcase
   end
   assign bus.miso     = r_miso;
   assign bus.ready    = (r_state != SHIFT);
   assign bus.tx_done  = r_done;
   assign bus.tx_abort = r_abort;
   assign bus.underrun = r_under;
endmodule
